// File: rtl/matmul_seq.sv
// matmul_seq: sequential N x N unsigned matrix multiplier.
// A and B are loaded as row-major element streams; C = A x B is computed with
// one shared multiply-accumulate, one product per clock, into a result
// register file readable by row/column address.
module matmul_seq #(
   parameter int N     = 2,
   parameter int WIDTH = 8,
   parameter int ACC_W = 2 * WIDTH + $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_valid,
   input  logic                 load_sel,
   input  logic [WIDTH-1:0]     load_data,
   output logic                 load_ready,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic [$clog2(N)-1:0] rd_row,
   input  logic [$clog2(N)-1:0] rd_col,
   output logic [ACC_W-1:0]     rd_data
);

   localparam int             IW   = $clog2(N);
   localparam logic [IW-1:0]  LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t           state_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] a_q [N][N];
   logic [WIDTH-1:0] b_q [N][N];
   logic [ACC_W-1:0] c_q [N][N];

   logic [IW-1:0]    a_row_q, a_col_q, b_row_q, b_col_q;
   logic [IW-1:0]    a_row_d, a_col_d, b_row_d, b_col_d;
   logic [IW-1:0]    i_q, j_q, k_q;
   logic [IW-1:0]    i_d, j_d, k_d;
   logic             i_last, j_last, k_last;
   logic [ACC_W-1:0] acc_q, acc_d, prod;
   logic             rd_in_range;

   assign busy       = busy_q;
   assign done       = done_q;
   // start has priority over a same-cycle load, so it also gates readiness
   assign load_ready = (state_q == S_IDLE) & ~start;

   // Next values for load pointers, loop counters and the MAC accumulator
   always_comb begin
      a_col_d = (a_col_q == LAST) ? '0 : a_col_q + 1'b1;
      a_row_d = a_row_q;
      if (a_col_q == LAST) begin
         a_row_d = (a_row_q == LAST) ? '0 : a_row_q + 1'b1;
      end
      b_col_d = (b_col_q == LAST) ? '0 : b_col_q + 1'b1;
      b_row_d = b_row_q;
      if (b_col_q == LAST) begin
         b_row_d = (b_row_q == LAST) ? '0 : b_row_q + 1'b1;
      end

      k_last = (k_q == LAST);
      j_last = (j_q == LAST);
      i_last = (i_q == LAST);
      k_d    = k_last ? '0 : k_q + 1'b1;
      j_d    = j_q;
      i_d    = i_q;
      if (k_last) begin
         j_d = j_last ? '0 : j_q + 1'b1;
         if (j_last) begin
            i_d = i_last ? '0 : i_q + 1'b1;
         end
      end

      prod  = ACC_W'(a_q[i_q][k_q]) * ACC_W'(b_q[k_q][j_q]);
      acc_d = ((k_q == '0) ? '0 : acc_q) + prod;
   end

   // Control FSM with operand loading, MAC sequencing and result write-back
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         a_q     <= '{default: '0};
         b_q     <= '{default: '0};
         c_q     <= '{default: '0};
         a_row_q <= '0;
         a_col_q <= '0;
         b_row_q <= '0;
         b_col_q <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= S_CALC;
                  busy_q  <= 1'b1;
                  a_row_q <= '0;
                  a_col_q <= '0;
                  b_row_q <= '0;
                  b_col_q <= '0;
                  i_q     <= '0;
                  j_q     <= '0;
                  k_q     <= '0;
                  acc_q   <= '0;
               end else if (load_valid) begin
                  if (load_sel) begin
                     b_q[b_row_q][b_col_q] <= load_data;
                     b_row_q <= b_row_d;
                     b_col_q <= b_col_d;
                  end else begin
                     a_q[a_row_q][a_col_q] <= load_data;
                     a_row_q <= a_row_d;
                     a_col_q <= a_col_d;
                  end
               end
            end
            S_CALC: begin
               acc_q <= acc_d;
               k_q   <= k_d;
               j_q   <= j_d;
               i_q   <= i_d;
               if (k_last) begin
                  c_q[i_q][j_q] <= acc_d;
               end
               if (k_last && j_last && i_last) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Addresses beyond N-1 only exist when N is not a power of two
   if ((2 ** IW) == N) begin : g_full_addr
      assign rd_in_range = 1'b1;
   end else begin : g_part_addr
      assign rd_in_range = (rd_row <= LAST) && (rd_col <= LAST);
   end

   // Combinational readout of the result register file
   always_comb begin
      rd_data = '0;
      if (rd_in_range) begin
         rd_data = c_q[rd_row][rd_col];
      end
   end

endmodule
